// File: rtl/ntt_result_buffer_pkg.sv
// Shared NTT definitions: default coefficient/ring geometry, buffer FSM encoding
// and the index bit-reversal used when draining in bit-reversed order.
package ntt_result_buffer_pkg;

    localparam int DATA_SIZE_ARB = 16;
    localparam int RING_SIZE     = 1024;
    localparam int RING_DEPTH    = $clog2(RING_SIZE);
    localparam int MAX_DEPTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // Reverses the low 'depth' bits of 'a'; bits above 'depth' come back as zero.
    function automatic logic [MAX_DEPTH-1:0] bit_reverse(input logic [MAX_DEPTH-1:0] a,
                                                         input int depth);
        logic [MAX_DEPTH-1:0] full_rev;
        full_rev = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            full_rev[i] = a[MAX_DEPTH-1-i];
        end
        return full_rev >> (MAX_DEPTH - depth);
    endfunction

endpackage

// File: rtl/ntt_result_buffer_ram.sv
// Simple dual-port coefficient RAM: one write port, one read port whose data
// register only advances on a read enable so a stalled word is held.
module ntt_buf_ram
    import ntt_result_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE_ARB,
    parameter int DEPTH  = RING_SIZE,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port; storage is deliberately never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port, held between read enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ntt_result_buffer.sv
// Captures one polynomial from an unthrottled NTT output stream, then drains it
// through a valid/ready port in natural or bit-reversed index order.
module ntt_result_buffer
    import ntt_result_buffer_pkg::*;
#(
    parameter int DATA_SIZE_ARB = ntt_result_buffer_pkg::DATA_SIZE_ARB,
    parameter int RING_SIZE     = ntt_result_buffer_pkg::RING_SIZE,
    parameter int BITREV        = 0,
    parameter int RING_DEPTH    = $clog2(RING_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ntt_done,
    input  logic [DATA_SIZE_ARB-1:0] ntt_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_SIZE_ARB-1:0] m_data,
    output logic [RING_DEPTH-1:0]    m_index,
    output logic                     m_last,
    output logic                     busy,
    output logic                     err_drop
);

    localparam logic [RING_DEPTH-1:0] CNT_LAST = RING_DEPTH'(RING_SIZE - 1);
    localparam logic [RING_DEPTH-1:0] CNT_ONE  = RING_DEPTH'(1);

    state_e                  state_q, state_d;
    logic [RING_DEPTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [RING_DEPTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic                    rd_done_q, rd_done_d;
    logic                    m_valid_q, m_valid_d;
    logic [RING_DEPTH-1:0]   m_index_q, m_index_d;
    logic                    m_last_q, m_last_d;
    logic                    busy_q, busy_d;
    logic                    err_drop_q, err_drop_d;
    logic                    we_s;
    logic                    re_s;
    logic                    hs_s;
    logic                    final_hs_s;
    logic [RING_DEPTH-1:0]   raddr_s;

    // Read address: drain counter, optionally bit-reversed.
    always_comb begin
        if (BITREV != 0) begin
            raddr_s = RING_DEPTH'(bit_reverse(MAX_DEPTH'(rd_cnt_q), RING_DEPTH));
        end else begin
            raddr_s = rd_cnt_q;
        end
    end

    // Next-state logic for the capture/drain sequencer and its outputs.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_done_d  = rd_done_q;
        m_valid_d  = m_valid_q;
        m_index_d  = m_index_q;
        m_last_d   = m_last_q;
        err_drop_d = err_drop_q;
        we_s       = 1'b0;
        re_s       = 1'b0;
        hs_s       = m_valid_q & m_ready;
        final_hs_s = hs_s & m_last_q;

        case (state_q)
            ST_IDLE: begin
                if (ntt_done) begin
                    state_d  = ST_CAPTURE;
                    wr_cnt_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                we_s     = 1'b1;
                wr_cnt_d = wr_cnt_q + CNT_ONE;
                if (wr_cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_CAPTURE;
                end
                if (ntt_done) begin
                    err_drop_d = 1'b1;
                end else begin
                    err_drop_d = err_drop_q;
                end
            end
            ST_DRAIN: begin
                if (hs_s) begin
                    m_valid_d = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
                // Refill the output slot whenever it is empty or being consumed.
                if (!rd_done_q && (!m_valid_q || m_ready)) begin
                    re_s      = 1'b1;
                    m_valid_d = 1'b1;
                    m_index_d = raddr_s;
                    m_last_d  = (rd_cnt_q == CNT_LAST);
                    rd_cnt_d  = rd_cnt_q + CNT_ONE;
                    rd_done_d = (rd_cnt_q == CNT_LAST);
                end else begin
                    re_s      = 1'b0;
                end
                if (final_hs_s) begin
                    m_last_d  = 1'b0;
                    rd_done_d = 1'b0;
                    rd_cnt_d  = '0;
                    if (ntt_done) begin
                        state_d  = ST_CAPTURE;
                        wr_cnt_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else if (ntt_done) begin
                    err_drop_d = 1'b1;
                end else begin
                    err_drop_d = err_drop_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_done_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_index_q  <= '0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_done_q  <= rd_done_d;
            m_valid_q  <= m_valid_d;
            m_index_q  <= m_index_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
            err_drop_q <= err_drop_d;
        end
    end

    ntt_buf_ram #(
        .DATA_W (DATA_SIZE_ARB),
        .DEPTH  (RING_SIZE),
        .ADDR_W (RING_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (we_s),
        .waddr (wr_cnt_q),
        .wdata (ntt_dout),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (m_data)
    );

    assign m_valid  = m_valid_q;
    assign m_index  = m_index_q;
    assign m_last   = m_last_q;
    assign busy     = busy_q;
    assign err_drop = err_drop_q;

endmodule

// File: tb/tb_ntt_result_buffer.sv
// Scoreboard bench: a natural-order and a bit-reversed buffer share one stimulus
// stream; expected drain sequences are queued at capture time and popped on handshakes.
module tb_ntt_result_buffer;

    localparam int W = 16;
    localparam int N = 1024;
    localparam int D = 10;

    typedef struct packed {
        logic         l;
        logic [D-1:0] i;
        logic [W-1:0] d;
    } word_t;

    logic         clk;
    logic         reset;
    logic         ntt_done;
    logic [W-1:0] ntt_dout;
    logic         m_ready;
    logic         m_valid0, m_last0, busy0, err0;
    logic [W-1:0] m_data0;
    logic [D-1:0] m_index0;
    logic         m_valid1, m_last1, busy1, err1;
    logic [W-1:0] m_data1;
    logic [D-1:0] m_index1;

    word_t exp_q0[$];
    word_t exp_q1[$];
    word_t held0, held1;
    bit    held_v0, held_v1;
    int    n_checks;
    int    n_fail;
    int    pops0;
    bit    rand_ready;

    ntt_result_buffer #(.DATA_SIZE_ARB(W), .RING_SIZE(N), .BITREV(0)) dut_nat (
        .clk(clk), .reset(reset), .ntt_done(ntt_done), .ntt_dout(ntt_dout),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_index(m_index0),
        .m_last(m_last0), .busy(busy0), .err_drop(err0)
    );

    ntt_result_buffer #(.DATA_SIZE_ARB(W), .RING_SIZE(N), .BITREV(1)) dut_rev (
        .clk(clk), .reset(reset), .ntt_done(ntt_done), .ntt_dout(ntt_dout),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_index(m_index1),
        .m_last(m_last1), .busy(busy1), .err_drop(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rev(input int j);
        int r;
        r = 0;
        for (int b = 0; b < D; b++) begin
            if (((j >> b) & 1) != 0) r = r | (1 << (D - 1 - b));
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int u, input logic v, input logic l,
                       input logic [D-1:0] i, input logic [W-1:0] d);
        word_t cur;
        word_t e;
        bit    hv;
        word_t hw;
        cur = '{l: l, i: i, d: d};
        hv  = (u == 0) ? held_v0 : held_v1;
        hw  = (u == 0) ? held0 : held1;
        if (hv) chk($sformatf("stall_hold[%0d]", u), int'({v, cur}), int'({1'b1, hw}));
        if (v && m_ready) begin
            if ((u == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word[%0d]: got 0x%0h, expected no word", u, cur);
            end else begin
                if (u == 0) begin
                    e = exp_q0.pop_front();
                    pops0++;
                end else begin
                    e = exp_q1.pop_front();
                end
                chk($sformatf("word[%0d]", u), int'(cur), int'(e));
            end
        end
        if (u == 0) begin
            held_v0 = v && !m_ready;
            held0   = cur;
        end else begin
            held_v1 = v && !m_ready;
            held1   = cur;
        end
    endtask

    // Monitor: sample both outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            mon(0, m_valid0, m_last0, m_index0, m_data0);
            mon(1, m_valid1, m_last1, m_index1, m_data1);
        end
    end

    // Consumer: always ready, or a fair coin each cycle in backpressure phases.
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [W-1:0] base, input int err_at);
        word_t e;
        for (int j = 0; j < N; j++) begin
            e = '{l: (j == N - 1), i: D'(j), d: W'(int'(base) + j)};
            exp_q0.push_back(e);
            e = '{l: (j == N - 1), i: D'(rev(j)), d: W'(int'(base) + rev(j))};
            exp_q1.push_back(e);
        end
        ntt_done = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            ntt_dout = W'(int'(base) + k);
            ntt_done = (k == err_at);
            step();
        end
        ntt_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy0 || busy1) && c < 6000) begin
            step();
            c++;
        end
        chk({name, "_complete"}, int'(c < 6000), 1);
        chk({name, "_idle"}, int'({m_valid0, m_valid1, busy0, busy1}), 0);
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic apply_reset(input string name);
        reset = 1'b1;
        #1;
        chk({name, "_outs_nat"}, int'({m_valid0, m_last0, busy0, err0, m_data0, m_index0}), 0);
        chk({name, "_outs_rev"}, int'({m_valid1, m_last1, busy1, err1, m_data1, m_index1}), 0);
        exp_q0.delete();
        exp_q1.delete();
        held_v0 = 1'b0;
        held_v1 = 1'b0;
        pops0   = 0;
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        n_checks   = 0;
        n_fail     = 0;
        pops0      = 0;
        rand_ready = 1'b0;
        held_v0    = 1'b0;
        held_v1    = 1'b0;
        m_ready    = 1'b1;
        ntt_done   = 1'b0;
        ntt_dout   = '0;
        apply_reset("reset0");

        // Natural and bit-reversed drains with a free-running consumer.
        capture(16'h0000, -1);
        chk("busy_after_capture", int'({busy0, busy1}), 3);
        wait_drain("natural");
        chk("err_clean", int'({err0, err1}), 0);

        // Random backpressure.
        rand_ready = 1'b1;
        capture(16'h2000, -1);
        wait_drain("backpressure");
        rand_ready = 1'b0;
        step();
        step();

        // ntt_done during capture is dropped and flagged.
        capture(16'h0100, 300);
        chk("err_drop_set", int'({err0, err1}), 3);
        wait_drain("dropped_done");
        chk("err_drop_sticky", int'({err0, err1}), 3);
        apply_reset("reset1");

        // New ntt_done exactly in the final-handshake cycle of the first drain.
        capture(16'h0000, -1);
        repeat (N) step();
        capture(16'h8000, -1);
        wait_drain("back_to_back");
        chk("b2b_no_drop", int'({err0, err1}), 0);

        // Reset mid-drain, then a fresh polynomial.
        capture(16'h4000, -1);
        c = 0;
        while (pops0 < 500 && c < 3000) begin
            step();
            c++;
        end
        chk("reach_word_500", int'(pops0 >= 500), 1);
        apply_reset("reset_mid_drain");
        capture(16'h5000, -1);
        wait_drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_result_buffer.md
NTT_RESULT_BUFFER -- requirements
Module: ntt_result_buffer

Interface
REQ-001 Parameter: DATA_SIZE_ARB, 16, coefficient width in bits.
REQ-002 Parameter: RING_SIZE, 1024, coefficients per polynomial (power of two); RING_DEPTH = clog2(RING_SIZE).
REQ-003 Parameter: BITREV, 0, 0 = drain in natural order, 1 = drain in bit-reversed index order.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ntt_done  input  1  NTT done flag.
REQ-007 ntt_dout  input  DATA_SIZE_ARB  NTT result stream; no backpressure.
REQ-008 m_valid  output  1  output word valid.
REQ-009 m_ready  input  1  consumer accepts the word when m_valid and m_ready are both high.
REQ-010 m_data  output  DATA_SIZE_ARB  output coefficient.
REQ-011 m_index  output  RING_DEPTH  capture index of m_data.
REQ-012 m_last  output  1  high with the final word of a polynomial.
REQ-013 busy  output  1  high in CAPTURE or DRAIN.
REQ-014 err_drop  output  1  sticky: ntt_done was ignored.

Function
REQ-015 FSM states IDLE, CAPTURE, DRAIN; the buffer holds one polynomial in a RING_SIZE x DATA_SIZE_ARB RAM.
REQ-016 IDLE: ntt_done sampled high in cycle D -> CAPTURE from cycle D+1.
REQ-017 CAPTURE: ntt_dout is written at address k in cycle D+1+k, k = 0..RING_SIZE-1, on every cycle with no gaps.
REQ-018 After the write of k = RING_SIZE-1 -> DRAIN on the next cycle; the write counter wraps to 0.
REQ-019 DRAIN: read address = k, or bit-reverse(k) when BITREV=1; RAM read latency is 1 cycle; m_valid first rises 1 cycle after DRAIN entry.
REQ-020 m_data, m_index and m_last are registered and stay stable while m_valid is high and m_ready is low.
REQ-021 With m_ready held high, throughput is one word per cycle with no bubbles after the first word.
REQ-022 m_index equals the RAM address read; m_last is high only for the word with drain count RING_SIZE-1.
REQ-023 A handshake on the m_last word -> IDLE on the next cycle, with m_valid low.
REQ-024 ntt_done high in CAPTURE, or in DRAIN outside the final-handshake cycle -> ignored; err_drop is set.
REQ-025 ntt_done high in the same cycle as the m_last handshake -> accepted as in REQ-016, and DRAIN goes directly to CAPTURE.
REQ-026 m_valid never rises in IDLE or CAPTURE; busy = (state != IDLE).
REQ-027 Data values are passed through unmodified; no arithmetic is performed on coefficients.

Reset
REQ-028 reset high -> immediately IDLE, counters 0, m_valid 0, m_data 0, m_index 0, m_last 0, busy 0, err_drop 0.
REQ-029 Reset in the middle of CAPTURE or DRAIN discards the polynomial; RAM contents are not cleared.
REQ-030 The first ntt_done after reset deasserts is handled per REQ-016.

Structure
REQ-031 DATA_SIZE_ARB, RING_SIZE, RING_DEPTH and the state encoding live in the shared NTT package.
REQ-032 The RAM is the sub-module ntt_buf_ram: simple dual port, 1 write and 1 registered read port, inferable as block RAM.
REQ-033 Bit reversal of the read address is a combinational function in the shared package.

Verification
REQ-034 Natural order: ntt_done pulse, then ntt_dout = k for k = 0..1023, m_ready = 1 -> m_data = 0..1023 in order, m_last only on 1023, then IDLE.
REQ-035 BITREV=1, same stimulus -> m_data sequence 0, 512, 256, 768, ...; m_index equals m_data; m_last on the 1024th word (1023).
REQ-036 Backpressure: m_ready random at 50% -> 1024 words are delivered, none duplicated or lost; held words are stable while stalled.
REQ-037 ntt_done pulsed at capture cycle 300 -> err_drop = 1; the captured data is unaffected.
REQ-038 ntt_done in the m_last handshake cycle -> the second polynomial (values 0x8000+k) is captured and drained correctly.
REQ-039 Reset asserted at drain word 500 -> all outputs 0 immediately; a new capture after reset delivers its 1024 words correctly.
